// File: rtl/ram_dp_arbiter.sv
// ram_dp_arbiter: two independent round-robin arbiters (write side and
// read side) that share a 16x8 dual-port RAM between two requesters each.
// Grants are combinational from the requests and the priority bits.
// Read data is returned with a registered per-requester valid strobe.
module ram_dp_arbiter #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_req0,
    input  logic          wr_req1,
    input  logic [AW-1:0] wr_addr0,
    input  logic [AW-1:0] wr_addr1,
    input  logic [DW-1:0] wr_data0,
    input  logic [DW-1:0] wr_data1,
    output logic          wr_gnt0,
    output logic          wr_gnt1,
    input  logic          rd_req0,
    input  logic          rd_req1,
    input  logic [AW-1:0] rd_addr0,
    input  logic [AW-1:0] rd_addr1,
    output logic          rd_gnt0,
    output logic          rd_gnt1,
    output logic          rd_valid0,
    output logic          rd_valid1,
    output logic [DW-1:0] rd_data,
    output logic          ram_we,
    output logic          ram_re,
    output logic [AW-1:0] ram_waddr,
    output logic [AW-1:0] ram_raddr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    // Priority bits: 0 favours requester 0, 1 favours requester 1.
    logic wpri_q, wpri_d;
    logic rpri_q, rpri_d;
    logic rd_valid0_q, rd_valid0_d;
    logic rd_valid1_q, rd_valid1_d;

    // Write grant: favoured requester wins on contention; nothing during reset.
    always_comb begin
        wr_gnt0 = 1'b0;
        wr_gnt1 = 1'b0;
        if (!rst) begin
            if (wr_req0 && (!wr_req1 || !wpri_q)) begin
                wr_gnt0 = 1'b1;
            end else if (wr_req1) begin
                wr_gnt1 = 1'b1;
            end
        end
    end

    // Read grant: same rule as the write side, on its own priority bit.
    always_comb begin
        rd_gnt0 = 1'b0;
        rd_gnt1 = 1'b0;
        if (!rst) begin
            if (rd_req0 && (!rd_req1 || !rpri_q)) begin
                rd_gnt0 = 1'b1;
            end else if (rd_req1) begin
                rd_gnt1 = 1'b1;
            end
        end
    end

    // RAM pin mux from the granted requesters; zero when idle.
    always_comb begin
        ram_we    = wr_gnt0 | wr_gnt1;
        ram_re    = rd_gnt0 | rd_gnt1;
        ram_waddr = '0;
        ram_wdata = '0;
        ram_raddr = '0;
        if (wr_gnt0) begin
            ram_waddr = wr_addr0;
            ram_wdata = wr_data0;
        end else if (wr_gnt1) begin
            ram_waddr = wr_addr1;
            ram_wdata = wr_data1;
        end
        if (rd_gnt0) begin
            ram_raddr = rd_addr0;
        end else if (rd_gnt1) begin
            ram_raddr = rd_addr1;
        end
    end

    // Next-state: priority flips away from the winner, holds when idle.
    always_comb begin
        wpri_d = wpri_q;
        rpri_d = rpri_q;
        if (wr_gnt0) begin
            wpri_d = 1'b1;
        end else if (wr_gnt1) begin
            wpri_d = 1'b0;
        end
        if (rd_gnt0) begin
            rpri_d = 1'b1;
        end else if (rd_gnt1) begin
            rpri_d = 1'b0;
        end
        rd_valid0_d = rd_gnt0;
        rd_valid1_d = rd_gnt1;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wpri_q      <= 1'b0;
            rpri_q      <= 1'b0;
            rd_valid0_q <= 1'b0;
            rd_valid1_q <= 1'b0;
        end else begin
            wpri_q      <= wpri_d;
            rpri_q      <= rpri_d;
            rd_valid0_q <= rd_valid0_d;
            rd_valid1_q <= rd_valid1_d;
        end
    end

    // A valid left over from the cycle before reset is masked during reset,
    // because the RAM data it would tag is being cleared in that same cycle.
    always_comb begin
        rd_valid0 = rd_valid0_q & ~rst;
        rd_valid1 = rd_valid1_q & ~rst;
        rd_data   = ram_rdata;
    end

endmodule

// File: tb/tb_ram_dp_arbiter.sv
// Bench for ram_dp_arbiter: a RAM model on the ram_* pins, a behavioural
// reference checked every cycle, and directed vectors with literal checks.
module tb_ram_dp_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_req0, wr_req1, rd_req0, rd_req1;
    logic [AW-1:0] wr_addr0, wr_addr1, rd_addr0, rd_addr1;
    logic [DW-1:0] wr_data0, wr_data1;
    logic          wr_gnt0, wr_gnt1, rd_gnt0, rd_gnt1;
    logic          rd_valid0, rd_valid1;
    logic [DW-1:0] rd_data;
    logic          ram_we, ram_re;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ram_dp_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .wr_req0(wr_req0), .wr_req1(wr_req1),
        .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
        .wr_data0(wr_data0), .wr_data1(wr_data1),
        .wr_gnt0(wr_gnt0), .wr_gnt1(wr_gnt1),
        .rd_req0(rd_req0), .rd_req1(rd_req1),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .rd_gnt0(rd_gnt0), .rd_gnt1(rd_gnt1),
        .rd_valid0(rd_valid0), .rd_valid1(rd_valid1),
        .rd_data(rd_data),
        .ram_we(ram_we), .ram_re(ram_re),
        .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // RAM attached to the arbiter: sync write, registered read, cleared by rst.
    logic [DW-1:0] ram_mem [16];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) ram_mem[i] <= '0;
            ram_rdata <= '0;
        end else begin
            if (ram_we) ram_mem[ram_waddr] <= ram_wdata;
            if (ram_re) ram_rdata <= ram_mem[ram_raddr];
        end
    end

    // Reference model state.
    logic [DW-1:0] m_mem [16];
    int            m_wfav = 0;
    int            m_rfav = 0;
    int            m_pend = -1;     // requester whose read returns next cycle
    int            m_pdata = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Winner of one arbiter: -1 none, else requester index.
    function automatic int winner(input logic r0, input logic r1, input int fav, input logic in_rst);
        if (in_rst) return -1;
        if (r0 && r1) return fav;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    // Per-cycle compare against the model, then advance the model across
    // the coming rising edge (inputs stay fixed until after that edge).
    always @(negedge clk) begin
        int wwin, rwin, ew_addr, ew_data, er_addr;
        wwin = winner(wr_req0, wr_req1, m_wfav, rst);
        rwin = winner(rd_req0, rd_req1, m_rfav, rst);
        ew_addr = (wwin == 0) ? int'(wr_addr0) : (wwin == 1) ? int'(wr_addr1) : 0;
        ew_data = (wwin == 0) ? int'(wr_data0) : (wwin == 1) ? int'(wr_data1) : 0;
        er_addr = (rwin == 0) ? int'(rd_addr0) : (rwin == 1) ? int'(rd_addr1) : 0;
        chk("m_wr_gnt0", int'(wr_gnt0), int'(wwin == 0));
        chk("m_wr_gnt1", int'(wr_gnt1), int'(wwin == 1));
        chk("m_rd_gnt0", int'(rd_gnt0), int'(rwin == 0));
        chk("m_rd_gnt1", int'(rd_gnt1), int'(rwin == 1));
        chk("m_ram_we", int'(ram_we), int'(wwin >= 0));
        chk("m_ram_re", int'(ram_re), int'(rwin >= 0));
        chk("m_ram_waddr", int'(ram_waddr), ew_addr);
        chk("m_ram_wdata", int'(ram_wdata), ew_data);
        chk("m_ram_raddr", int'(ram_raddr), er_addr);
        chk("m_rd_valid0", int'(rd_valid0), int'(!rst && m_pend == 0));
        chk("m_rd_valid1", int'(rd_valid1), int'(!rst && m_pend == 1));
        if (!rst && m_pend >= 0) chk("m_rd_data", int'(rd_data), m_pdata);
        if (rst) begin
            m_wfav = 0;
            m_rfav = 0;
            m_pend = -1;
            for (int i = 0; i < 16; i++) m_mem[i] = '0;
        end else begin
            m_pend = rwin;
            if (rwin >= 0) m_pdata = int'(m_mem[er_addr]);   // old contents
            if (wwin >= 0) m_mem[ew_addr] = DW'(ew_data);
            if (wwin >= 0) m_wfav = 1 - wwin;
            if (rwin >= 0) m_rfav = 1 - rwin;
        end
    end

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_req0 = 0; wr_req1 = 0; rd_req0 = 0; rd_req1 = 0;
    endtask

    initial begin
        rst = 1;
        wr_req0 = 1; wr_req1 = 1; rd_req0 = 1; rd_req1 = 1;
        wr_addr0 = 4'd7; wr_data0 = 8'h77;
        wr_addr1 = 4'd8; wr_data1 = 8'h88;
        rd_addr0 = 4'd7; rd_addr1 = 4'd8;

        // Reset held two cycles with every request high.
        for (int i = 0; i < 2; i++) begin
            mid();
            chk("rst_wgnt", int'({wr_gnt1, wr_gnt0}), 0);
            chk("rst_rgnt", int'({rd_gnt1, rd_gnt0}), 0);
            chk("rst_ram_en", int'({ram_we, ram_re}), 0);
            chk("rst_valid", int'({rd_valid1, rd_valid0}), 0);
            cyc();
        end

        // After release requester 0 wins first, then 1.
        rst = 0;
        mid();
        chk("post_rst_wgnt", int'({wr_gnt1, wr_gnt0}), 1);
        chk("post_rst_rgnt", int'({rd_gnt1, rd_gnt0}), 1);
        cyc();
        mid();
        chk("second_wgnt", int'({wr_gnt1, wr_gnt0}), 2);
        chk("second_rgnt", int'({rd_gnt1, rd_gnt0}), 2);
        chk("first_rvalid0", int'(rd_valid0), 1);
        chk("first_rdata_old", int'(rd_data), 8'h00);
        cyc();
        idle();
        mid();
        chk("second_rvalid1", int'(rd_valid1), 1);
        cyc();

        // Single write then read.
        wr_req0 = 1; wr_addr0 = 4'd3; wr_data0 = 8'hA5;
        mid();
        chk("single_wgnt0", int'(wr_gnt0), 1);
        cyc();
        wr_req0 = 0; rd_req1 = 1; rd_addr1 = 4'd3;
        mid();
        chk("single_rgnt1", int'(rd_gnt1), 1);
        chk("single_raddr", int'(ram_raddr), 3);
        cyc();
        rd_req1 = 0;
        mid();
        chk("single_rvalid1", int'(rd_valid1), 1);
        chk("single_rvalid0", int'(rd_valid0), 0);
        chk("single_rdata", int'(rd_data), 8'hA5);
        cyc();

        // Bring the write pointer back to 0 with a lone write from requester 1.
        wr_req1 = 1; wr_addr1 = 4'd9; wr_data1 = 8'h99;
        mid();
        chk("lone_wgnt1", int'(wr_gnt1), 1);
        cyc();
        wr_req1 = 0;

        // Write contention: grants alternate 0,1,0,1.
        wr_req0 = 1; wr_addr0 = 4'd1; wr_data0 = 8'h11;
        wr_req1 = 1; wr_addr1 = 4'd2; wr_data1 = 8'h22;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("wcont_gnt", int'({wr_gnt1, wr_gnt0}), (i % 2 == 0) ? 1 : 2);
            cyc();
        end
        idle();

        // Read contention: valids alternate, data follows the address.
        rd_req0 = 1; rd_addr0 = 4'd1;
        rd_req1 = 1; rd_addr1 = 4'd2;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) idle();
            mid();
            if (i < 4) chk("rcont_gnt", int'({rd_gnt1, rd_gnt0}), (i % 2 == 0) ? 1 : 2);
            if (i > 0) begin
                chk("rcont_valid", int'({rd_valid1, rd_valid0}), (i % 2 == 1) ? 1 : 2);
                chk("rcont_data", int'(rd_data), (i % 2 == 1) ? 8'h11 : 8'h22);
            end
            cyc();
        end

        // Same-address collision: read returns old data, next read new data.
        wr_req0 = 1; wr_addr0 = 4'd5; wr_data0 = 8'h33;
        mid();
        cyc();
        wr_data0 = 8'h44;
        rd_req0 = 1; rd_addr0 = 4'd5;
        mid();
        chk("coll_both", int'({wr_gnt0, rd_gnt0}), 3);
        cyc();
        wr_req0 = 0;
        mid();
        chk("coll_old", int'(rd_data), 8'h33);
        chk("coll_valid0", int'(rd_valid0), 1);
        cyc();
        rd_req0 = 0;
        mid();
        chk("coll_new", int'(rd_data), 8'h44);
        cyc();

        // Reset mid-read: pending valid is dropped and the RAM is cleared.
        rd_req0 = 1; rd_addr0 = 4'd5;
        mid();
        chk("rmid_gnt0", int'(rd_gnt0), 1);
        cyc();
        rd_req0 = 0; rst = 1;
        mid();
        chk("rmid_valid0", int'(rd_valid0), 0);
        cyc();
        rst = 0; rd_req1 = 1; rd_addr1 = 4'd5;
        mid();
        chk("rmid_rgnt1", int'(rd_gnt1), 1);
        cyc();
        rd_req1 = 0;
        mid();
        chk("rmid_rvalid1", int'(rd_valid1), 1);
        chk("rmid_cleared", int'(rd_data), 8'h00);
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
